// File: rtl/mac_sched_pkg.sv
// Shared types and defaults for the MAC channel scheduler.
// Optional feature macro: MAC_SCHED_WDOG_EN (RUN-state watchdog).
package mac_sched_pkg;

    // Scheduler control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        RUN   = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_ADDR_LINES = 5;

    // One extra bit over the term-count width so a channel can hold
    // up to 2^(ADDR_LINES+1)-1 pending items.
    function automatic int cred_width(input int addr_lines);
        return addr_lines + 1;
    endfunction

    localparam int DEF_CRED_W = cred_width(DEF_ADDR_LINES);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational pointer-based round-robin picker: the search starts at
// ptr_i and wraps from N-1 to 0; the first requester found wins.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Walk the request vector from the pointer, taking the first hit.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] c;
        // NOTE: every output gets a default before the loop so no path
        // leaves a signal unassigned, which would infer a latch.
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            c = sum[IW-1:0];
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = c;
            end
        end
    end

endmodule

// File: rtl/mac_channel_scheduler.sv
// Round-robin scheduler sharing one MAC controller among NUM_CH channels.
// Tracks per-channel credits, offers one job at a time and waits for the
// MAC to finish before granting again.
// Optional feature macro: MAC_SCHED_WDOG_EN adds a RUN-state watchdog.
module mac_channel_scheduler
    import mac_sched_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ADDR_LINES  = DEF_ADDR_LINES,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                         mac_credit_clk_i,
    input  logic                         rstn_i,
    input  logic [NUM_CH-1:0]            ch_wr_i,
    input  logic [NUM_CH*ADDR_LINES-1:0] ch_terms_i,
    input  logic                         halt_i,
    output logic                         job_valid_o,
    input  logic                         job_ready_i,
    output logic [$clog2(NUM_CH)-1:0]    job_ch_o,
    output logic [ADDR_LINES-1:0]        job_terms_o,
    input  logic                         mac_done_i,
    output logic [NUM_CH-1:0]            ch_pop_o,
    output logic                         busy_o,
    output logic [NUM_CH-1:0]            ovf_err_o,
    output logic                         wdog_err_o
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CRED_W = cred_width(ADDR_LINES);

    sched_state_t state_q, state_d;

    logic [CRED_W-1:0]     credit_q [NUM_CH];
    logic [CRED_W-1:0]     credit_d [NUM_CH];
    logic [NUM_CH-1:0]     ovf_q, ovf_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  job_valid_q, job_valid_d;
    logic [CH_W-1:0]       job_ch_q, job_ch_d;
    logic [ADDR_LINES-1:0] job_terms_q, job_terms_d;
    logic [NUM_CH-1:0]     ch_pop_q, ch_pop_d;
    logic                  busy_q, busy_d;

    logic [ADDR_LINES-1:0] terms [NUM_CH];
    logic [NUM_CH-1:0]     eligible;
    logic [NUM_CH-1:0]     arb_gnt;
    logic [CH_W-1:0]       arb_idx;
    logic                  arb_any;
    logic                  grant;
    logic                  accept;

    // Unpack term counts and flag channels that have work and a non-zero job.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            terms[k]    = ch_terms_i[k*ADDR_LINES +: ADDR_LINES];
            eligible[k] = (credit_q[k] != '0) && (terms[k] != '0);
        end
    end

    rr_arbiter #(.N(NUM_CH)) u_rr_arbiter (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign grant  = (state_q == IDLE) && !halt_i && arb_any;
    assign accept = job_valid_q && job_ready_i;

`ifdef MAC_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
    logic              wdog_expire;

    // Expire on the last allowed RUN cycle unless the MAC finishes in it.
    assign wdog_expire = (state_q == RUN) && !mac_done_i &&
                         (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

    // Count cycles spent in RUN; the flag is sticky until reset.
    always_comb begin
        wdog_cnt_d = (state_q == RUN) ? wdog_cnt_q + 1'b1 : '0;
        wdog_err_d = wdog_err_q | wdog_expire;
    end

    // Watchdog registers.
    always_ff @(posedge mac_credit_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err_o = wdog_err_q;
`else
    // Watchdog compiled out: RUN waits for mac_done_i indefinitely.
    assign wdog_err_o = 1'b0;

    // WDOG_CYCLES stays in the shared parameter list; an out-of-range
    // value shows up as this marker scope in the elaborated hierarchy.
    if (WDOG_CYCLES < 1) begin : g_wdog_cycles_invalid
    end
`endif

    // Credit bookkeeping: write adds, accept removes, both together cancel.
    always_comb begin
        logic inc;
        logic dec;
        ovf_d = ovf_q;
        for (int k = 0; k < NUM_CH; k++) begin
            credit_d[k] = credit_q[k];
            inc = ch_wr_i[k];
            dec = accept && (job_ch_q == CH_W'(k));
            if (inc && !dec) begin
                if (&credit_q[k]) begin
                    ovf_d[k] = 1'b1;
                end else begin
                    credit_d[k] = credit_q[k] + 1'b1;
                end
            end else if (dec && !inc) begin
                credit_d[k] = credit_q[k] - 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge mac_credit_clk_i or negedge rstn_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)       state_d = OFFER;
            OFFER:   if (job_ready_i) state_d = RUN;
            RUN: begin
                if (mac_done_i) state_d = IDLE;
`ifdef MAC_SCHED_WDOG_EN
                if (wdog_expire) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: next values for the registered outputs and pointer.
    always_comb begin
        job_valid_d = (state_d == OFFER);
        busy_d      = (state_d != IDLE);
        job_ch_d    = job_ch_q;
        job_terms_d = job_terms_q;
        if (grant) begin
            job_ch_d    = arb_idx;
            job_terms_d = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (arb_gnt[k]) begin
                    job_terms_d = job_terms_d | terms[k];
                end
            end
        end
        ch_pop_d = '0;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            ch_pop_d[job_ch_q] = 1'b1;
            rr_ptr_d = (job_ch_q == CH_W'(NUM_CH - 1)) ? '0 : job_ch_q + 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge mac_credit_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: the credit array is a bank of flops, not a RAM, and is
            // cleared here because a reset must drop every pending credit.
            for (int k = 0; k < NUM_CH; k++) begin
                credit_q[k] <= '0;
            end
            ovf_q       <= '0;
            rr_ptr_q    <= '0;
            job_valid_q <= 1'b0;
            job_ch_q    <= '0;
            job_terms_q <= '0;
            ch_pop_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                credit_q[k] <= credit_d[k];
            end
            ovf_q       <= ovf_d;
            rr_ptr_q    <= rr_ptr_d;
            job_valid_q <= job_valid_d;
            job_ch_q    <= job_ch_d;
            job_terms_q <= job_terms_d;
            ch_pop_q    <= ch_pop_d;
            busy_q      <= busy_d;
        end
    end

    assign job_valid_o = job_valid_q;
    assign job_ch_o    = job_ch_q;
    assign job_terms_o = job_terms_q;
    assign ch_pop_o    = ch_pop_q;
    assign busy_o      = busy_q;
    assign ovf_err_o   = ovf_q;

endmodule
